// File: rtl/ex_div_unit.sv
// EX-stage iterative divider: restoring shift-subtract, one bit per cycle.
// Handles RISC-V DIV/DIVU/REM/REMU including divide-by-zero and overflow.
module ex_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            stall_in,
  input  logic            flush,
  output logic            stall_req,
  output logic [XLEN-1:0] result,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [5:0] LAST = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic [5:0]      cnt;
  logic            rem_q;
  logic            qneg_q;
  logic            rneg_q;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;

  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] special;

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] rem_n;
  logic [XLEN-1:0] quo_n;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] fin;

  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & dividend[XLEN-1];
    b_neg     = is_signed & divisor[XLEN-1];
    a_abs     = a_neg ? -dividend : dividend;
    b_abs     = b_neg ? -divisor : divisor;
    div_zero  = (divisor == '0);
    ovf       = is_signed & (dividend == MIN_NEG) & (&divisor);
    if (div_zero)
      special = op[1] ? dividend : '1;
    else
      special = op[1] ? '0 : dividend;
  end

  // one restoring step: shift next dividend bit in, subtract if it fits
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, dvs};
    fits    = ~diff[XLEN];
    rem_n   = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_n   = {quo[XLEN-2:0], fits};
    q_fix   = qneg_q ? -quo_n : quo_n;
    r_fix   = rneg_q ? -rem_n : rem_n;
    fin     = rem_q ? r_fix : q_fix;
  end

  always_comb begin
    stall_req = 1'b0;
    if (!rst && !flush)
      stall_req = ((state == IDLE) & start) | (state == BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rem_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            rem_q  <= op[1];
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            quo    <= a_abs;
            rem    <= '0;
            dvs    <= b_abs;
            cnt    <= '0;
            if (div_zero || ovf) begin
              result <= special;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          quo <= quo_n;
          rem <= rem_n;
          cnt <= cnt + 6'd1;
          if (cnt == LAST) begin
            result <= fin;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          if (!stall_in) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// Randomized + directed bench for ex_div_unit against an arithmetic model.
// Timing of stall_req/done is checked per operation; results every done cycle.
module tb_ex_div_unit;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        stall_in;
  logic        flush;
  logic        stall_req;
  logic [31:0] result;
  logic        done;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_result = '0;

  always #5 clk = ~clk;

  ex_div_unit #(.XLEN(XLEN)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(op),
    .dividend(dividend),
    .divisor(divisor),
    .stall_in(stall_in),
    .flush(flush),
    .stall_req(stall_req),
    .result(result),
    .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RISC-V M-extension semantics from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [1:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (o)
      2'b00: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      2'b01: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return 32'(ua / ub);
      end
      2'b10: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return 32'(ua % ub);
      end
    endcase
  endfunction

  function automatic int exp_stalls(input logic [1:0] o,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    if (b == 0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // issue one op with start held; stall_in held for `hold` DONE cycles
  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int hold,
                        output logic [31:0] got);
    int nst;
    int dcnt;
    int cyc;
    nst = 0;
    dcnt = 0;
    cyc = 0;
    got = '0;
    exp_result = model(o, a, b);
    op = o;
    dividend = a;
    divisor = b;
    start = 1'b1;
    while (cyc < 200) begin
      #1;
      if (done) begin
        if (dcnt == 0) got = result;
        dcnt++;
        stall_in = (dcnt <= hold);
      end else if (dcnt > 0) begin
        break;
      end else if (stall_req) begin
        nst++;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    stall_in = 1'b0;
    chk("op_timeout", 32'(cyc < 200), 32'd1);
    chk("stall_cycles", 32'(nst), 32'(exp_stalls(o, a, b)));
    chk("done_cycles", 32'(dcnt), 32'(hold + 1));
  endtask

  always @(negedge clk) begin
    #2;
    if (rst) begin
      chk("stall_req_in_reset", 32'(stall_req), 32'd0);
    end else if (done) begin
      chk("result", result, exp_result);
      chk("stall_req_in_done", 32'(stall_req), 32'd0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          dc;
    rst = 1'b1;
    start = 1'b1;
    op = 2'b01;
    dividend = 32'd100;
    divisor = 32'd7;
    stall_in = 1'b0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    #1;
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_stall_req", 32'(stall_req), 32'd0);

    run_op(2'b01, 32'd100, 32'd7, 0, g);
    chk("divu_100_7", g, 32'd14);
    run_op(2'b11, 32'd100, 32'd7, 0, g);
    chk("remu_100_7", g, 32'd2);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 0, g);
    chk("div_m7_2", g, 32'hFFFF_FFFD);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, g);
    chk("rem_m7_2", g, 32'hFFFF_FFFF);
    run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 0, g);
    chk("div_7_m2", g, 32'hFFFF_FFFD);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0, g);
    chk("rem_7_m2", g, 32'd1);
    run_op(2'b01, 32'd5, 32'd0, 0, g);
    chk("divu_5_0", g, 32'hFFFF_FFFF);
    run_op(2'b10, 32'd5, 32'd0, 0, g);
    chk("rem_5_0", g, 32'd5);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, g);
    chk("div_ovf", g, 32'h8000_0000);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, g);
    chk("rem_ovf", g, 32'd0);
    run_op(2'b01, 32'd1000, 32'd10, 3, g);
    chk("divu_held", g, 32'd100);
    run_op(2'b01, 32'd77, 32'd5, 0, g);
    chk("divu_after_hold", g, 32'd15);

    // flush at BUSY iteration 10
    exp_result = model(2'b01, 32'hDEAD_BEEF, 32'd3);
    op = 2'b01;
    dividend = 32'hDEAD_BEEF;
    divisor = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    chk("busy_stall_req", 32'(stall_req), 32'd1);
    flush = 1'b1;
    #1;
    chk("flush_stall_req", 32'(stall_req), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("post_flush_stall_req", 32'(stall_req), 32'd0);
    chk("post_flush_done", 32'(done), 32'd0);
    dc = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (done) dc++;
    end
    chk("flush_no_done", 32'(dc), 32'd0);
    run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 0, g);
    chk("rem_m100_7", g, 32'hFFFF_FFFE);

    // reset at BUSY iteration 20, start high during reset
    op = 2'b01;
    dividend = 32'd12345;
    divisor = 32'd11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    #1;
    chk("rst_stall_req", 32'(stall_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    #1;
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_result", result, 32'd0);
    chk("post_rst_stall_req", 32'(stall_req), 32'd0);
    run_op(2'b01, 32'd9, 32'd3, 0, g);
    chk("divu_9_3", g, 32'd3);

    for (int i = 0; i < 250; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin
          ra = 32'h8000_0000;
          rb = 32'hFFFF_FFFF;
        end
        3: ra = 32'h8000_0000;
        4: ra = ra >> $urandom_range(0, 31);
        default: ;
      endcase
      run_op(ro, ra, rb, $urandom_range(0, 2), g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
